// File: rtl/support_memory_arb.sv
// Arbitrated, write-protected single port onto the supervisor RAM.
// Two masters (support CPU, system loader) share it via req/ack; CPU writes into a window can be blocked.
module support_memory_arb #(
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 8,
  parameter int unsigned WP_LO  = 0,
  parameter int unsigned WP_HI  = 0,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset_n,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,

  input  logic          sys_en,
  input  logic          sys_req,
  input  logic          sys_we,
  input  logic [AW-1:0] sys_addr,
  input  logic [DW-1:0] sys_wdata,
  output logic [DW-1:0] sys_rdata,
  output logic          sys_ack,

  input  logic          wp_enable,
  input  logic          viol_clr,
  output logic          wp_viol,
  output logic [AW-1:0] wp_viol_addr,

  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWr   = 2'd1;
  localparam logic [1:0] StRd   = 2'd2;
  localparam logic [1:0] StAck  = 2'd3;

  localparam bit          WinValid = (WP_HI >= WP_LO);
  localparam logic [AW-1:0] WpLo    = AW'(WP_LO);
  localparam logic [AW-1:0] WinSpan = AW'(WP_HI - WP_LO);
  // RD is held RD_LAT+1 cycles: one for the address to reach the macro, RD_LAT for the data.
  localparam logic [1:0]  RdLast   = 2'(RD_LAT);

  logic [1:0]    state_q, state_d;
  logic          master_q, master_d;   // 1 = loader owns the in-flight access
  logic [1:0]    rd_cnt_q, rd_cnt_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic          ram_we_q, ram_we_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          sys_ack_q, sys_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] sys_rdata_q, sys_rdata_d;
  logic          wp_viol_q, wp_viol_d;
  logic [AW-1:0] wp_viol_addr_q, wp_viol_addr_d;

  logic          grant_cpu, grant_sys, grant_we, cpu_prot;
  logic [AW-1:0] win_off;

  always_comb begin
    grant_sys = (state_q == StIdle) & sys_en & sys_req;
    grant_cpu = (state_q == StIdle) & ~sys_en & cpu_req;
    grant_we  = grant_sys ? sys_we : cpu_we;
    // Wrapping offset: addresses below WP_LO land above the span and fall outside.
    win_off   = cpu_addr - WpLo;
    cpu_prot  = grant_cpu & cpu_we & wp_enable & WinValid & (win_off <= WinSpan);
  end

  always_comb begin
    state_d     = state_q;
    master_d    = master_q;
    rd_cnt_d    = rd_cnt_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    cpu_ack_d   = 1'b0;
    sys_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    sys_rdata_d = sys_rdata_q;

    case (state_q)
      StIdle: begin
        if (grant_sys || grant_cpu) begin
          master_d    = grant_sys;
          ram_addr_d  = grant_sys ? sys_addr : cpu_addr;
          ram_wdata_d = grant_sys ? sys_wdata : cpu_wdata;
          rd_cnt_d    = 2'd0;
          if (grant_we) begin
            state_d  = StWr;
            ram_we_d = ~cpu_prot;
          end else begin
            state_d = StRd;
          end
        end
      end
      StWr: begin
        state_d   = StAck;
        cpu_ack_d = ~master_q;
        sys_ack_d = master_q;
      end
      StRd: begin
        if (rd_cnt_q == RdLast) begin
          state_d   = StAck;
          cpu_ack_d = ~master_q;
          sys_ack_d = master_q;
          if (master_q) begin
            sys_rdata_d = ram_q;
          end else begin
            cpu_rdata_d = ram_q;
          end
        end else begin
          rd_cnt_d = rd_cnt_q + 2'd1;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // A new violation beats a simultaneous clear and reloads the captured address.
  always_comb begin
    wp_viol_d      = wp_viol_q;
    wp_viol_addr_d = wp_viol_addr_q;
    if (cpu_prot) begin
      wp_viol_d = 1'b1;
      if (!wp_viol_q || viol_clr) begin
        wp_viol_addr_d = cpu_addr;
      end
    end else if (viol_clr) begin
      wp_viol_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      master_q       <= 1'b0;
      rd_cnt_q       <= 2'd0;
      ram_addr_q     <= '0;
      ram_wdata_q    <= '0;
      ram_we_q       <= 1'b0;
      cpu_ack_q      <= 1'b0;
      sys_ack_q      <= 1'b0;
      cpu_rdata_q    <= '0;
      sys_rdata_q    <= '0;
      wp_viol_q      <= 1'b0;
      wp_viol_addr_q <= '0;
    end else begin
      state_q        <= state_d;
      master_q       <= master_d;
      rd_cnt_q       <= rd_cnt_d;
      ram_addr_q     <= ram_addr_d;
      ram_wdata_q    <= ram_wdata_d;
      ram_we_q       <= ram_we_d;
      cpu_ack_q      <= cpu_ack_d;
      sys_ack_q      <= sys_ack_d;
      cpu_rdata_q    <= cpu_rdata_d;
      sys_rdata_q    <= sys_rdata_d;
      wp_viol_q      <= wp_viol_d;
      wp_viol_addr_q <= wp_viol_addr_d;
    end
  end

  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign ram_we       = ram_we_q;
  assign cpu_ack      = cpu_ack_q;
  assign sys_ack      = sys_ack_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign sys_rdata    = sys_rdata_q;
  assign wp_viol      = wp_viol_q;
  assign wp_viol_addr = wp_viol_addr_q;

endmodule

// File: tb/tb_support_memory_arb.sv
// Bench for support_memory_arb: two instances (RD_LAT 1 and 3), each on a behavioural RAM,
// driven with random transactions and compared to a transaction-level reference model.
module tb_support_memory_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic        cpu_req [2], cpu_we [2], cpu_ack [2];
  logic [15:0] cpu_addr [2];
  logic [7:0]  cpu_wdata [2], cpu_rdata [2];
  logic        sys_en [2], sys_req [2], sys_we [2], sys_ack [2];
  logic [15:0] sys_addr [2];
  logic [7:0]  sys_wdata [2], sys_rdata [2];
  logic        wp_enable [2], viol_clr [2], wp_viol [2];
  logic [15:0] wp_viol_addr [2], ram_addr [2];
  logic [7:0]  ram_wdata [2];
  logic        ram_we [2];
  logic [7:0]  q0, q1;

  support_memory_arb #(.AW(16), .DW(8), .WP_LO(0), .WP_HI('h3FFF), .RD_LAT(1)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_rdata(cpu_rdata[0]), .cpu_ack(cpu_ack[0]),
    .sys_en(sys_en[0]), .sys_req(sys_req[0]), .sys_we(sys_we[0]), .sys_addr(sys_addr[0]),
    .sys_wdata(sys_wdata[0]), .sys_rdata(sys_rdata[0]), .sys_ack(sys_ack[0]),
    .wp_enable(wp_enable[0]), .viol_clr(viol_clr[0]), .wp_viol(wp_viol[0]),
    .wp_viol_addr(wp_viol_addr[0]),
    .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]), .ram_we(ram_we[0]), .ram_q(q0)
  );

  support_memory_arb #(.AW(16), .DW(8), .WP_LO(0), .WP_HI('h3FFF), .RD_LAT(3)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_rdata(cpu_rdata[1]), .cpu_ack(cpu_ack[1]),
    .sys_en(sys_en[1]), .sys_req(sys_req[1]), .sys_we(sys_we[1]), .sys_addr(sys_addr[1]),
    .sys_wdata(sys_wdata[1]), .sys_rdata(sys_rdata[1]), .sys_ack(sys_ack[1]),
    .wp_enable(wp_enable[1]), .viol_clr(viol_clr[1]), .wp_viol(wp_viol[1]),
    .wp_viol_addr(wp_viol_addr[1]),
    .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]), .ram_we(ram_we[1]), .ram_q(q1)
  );

  // Synchronous RAM macros: data appears RD_LAT cycles after the address.
  logic [7:0] mem0 [65536];
  logic [7:0] mem1 [65536];
  logic [7:0] p1a, p1b, p1c;
  always @(posedge clk) begin
    if (ram_we[0]) mem0[ram_addr[0]] <= ram_wdata[0];
    q0 <= mem0[ram_addr[0]];
    if (ram_we[1]) mem1[ram_addr[1]] <= ram_wdata[1];
    p1a <= mem1[ram_addr[1]];
    p1b <= p1a;
    p1c <= p1b;
  end
  assign q1 = p1c;

  // Reference model state
  logic [7:0]  ref_mem [int];
  bit          ref_viol [2];
  logic [15:0] ref_vaddr [2];
  logic [15:0] pool [8] = '{16'h0000, 16'h0100, 16'h0200, 16'h1234,
                            16'h3FFF, 16'h4000, 16'h8000, 16'hFFFF};

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at #1 after a rising edge with the DUT idle; returns at #1 after the edge following ack.
  task automatic access(input int idx, input bit sys, input bit we, input logic [15:0] a,
                        input logic [7:0] d, input bit wpe, input bit clr, input bit other,
                        input bit flip);
    int key, lat, n, wecnt;
    bit prot, got, bad, wa_ok, obs_viol;
    logic [7:0]  rd_obs;
    logic [15:0] obs_vaddr;
    key  = idx * 65536 + int'(a);
    prot = !sys && we && wpe && (a <= 16'h3FFF);
    lat  = we ? 2 : ((idx == 0) ? 1 : 3) + 2;

    sys_en[idx] = sys;
    wp_enable[idx] = wpe;
    viol_clr[idx] = clr;
    if (sys) begin
      sys_req[idx] = 1'b1; sys_we[idx] = we; sys_addr[idx] = a; sys_wdata[idx] = d;
      cpu_req[idx] = other; cpu_we[idx] = 1'($urandom);
      cpu_addr[idx] = 16'($urandom); cpu_wdata[idx] = 8'($urandom);
    end else begin
      cpu_req[idx] = 1'b1; cpu_we[idx] = we; cpu_addr[idx] = a; cpu_wdata[idx] = d;
      sys_req[idx] = other; sys_we[idx] = 1'($urandom);
      sys_addr[idx] = 16'($urandom); sys_wdata[idx] = 8'($urandom);
    end

    n = 99; got = 0; bad = 0; wa_ok = 1; wecnt = 0;
    rd_obs = '0; obs_viol = 0; obs_vaddr = '0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (ram_we[idx]) begin
        wecnt++;
        if (ram_addr[idx] !== a || ram_wdata[idx] !== d) wa_ok = 0;
      end
      if (sys ? cpu_ack[idx] : sys_ack[idx]) bad = 1;
      if (sys ? sys_ack[idx] : cpu_ack[idx]) begin
        got = 1;
        n = c;
        rd_obs = sys ? sys_rdata[idx] : cpu_rdata[idx];
        obs_viol = wp_viol[idx];
        obs_vaddr = wp_viol_addr[idx];
      end
      @(posedge clk);
      #1;
      viol_clr[idx] = 1'b0;
      if (flip && c == 0) sys_en[idx] = !sys;
    end
    cpu_req[idx] = 1'b0;
    sys_req[idx] = 1'b0;

    if (prot) begin
      if (!ref_viol[idx] || clr) ref_vaddr[idx] = a;
      ref_viol[idx] = 1;
    end else if (clr) begin
      ref_viol[idx] = 0;
    end

    check("ack_seen", 32'(got), 32'd1);
    check("ack_latency", 32'(n), 32'(lat));
    check("ram_we_cycles", 32'(wecnt), (we && !prot) ? 32'd1 : 32'd0);
    if (wecnt > 0) check("ram_write_bus", 32'(wa_ok), 32'd1);
    check("foreign_ack", 32'(bad), 32'd0);
    if (!we && ref_mem.exists(key)) check("rdata", 32'(rd_obs), 32'(ref_mem[key]));
    check("wp_viol", 32'(obs_viol), 32'(ref_viol[idx]));
    if (ref_viol[idx]) check("wp_viol_addr", 32'(obs_vaddr), 32'(ref_vaddr[idx]));

    if (we && !prot) ref_mem[key] = d;
  endtask

  task automatic rand_access(input int idx);
    access(idx, 1'($urandom), 1'($urandom), pool[$urandom_range(0, 7)], 8'($urandom),
           1'($urandom), $urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom));
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 2; i++) begin
      cpu_req[i] = 0; cpu_we[i] = 0; cpu_addr[i] = '0; cpu_wdata[i] = '0;
      sys_en[i] = 0; sys_req[i] = 0; sys_we[i] = 0; sys_addr[i] = '0; sys_wdata[i] = '0;
      wp_enable[i] = 0; viol_clr[i] = 0;
      ref_viol[i] = 0; ref_vaddr[i] = '0;
    end
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_cpu_ack", 32'(cpu_ack[i]), 32'd0);
      check("rst_sys_ack", 32'(sys_ack[i]), 32'd0);
      check("rst_ram_we", 32'(ram_we[i]), 32'd0);
      check("rst_wp_viol", 32'(wp_viol[i]), 32'd0);
      check("rst_viol_addr", 32'(wp_viol_addr[i]), 32'd0);
      check("rst_ram_addr", 32'(ram_addr[i]), 32'd0);
      check("rst_ram_wdata", 32'(ram_wdata[i]), 32'd0);
      check("rst_cpu_rdata", 32'(cpu_rdata[i]), 32'd0);
      check("rst_sys_rdata", 32'(sys_rdata[i]), 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Loader fills every pool address, window enabled: never protected.
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 8; k++)
        access(i, 1, 1, pool[k], 8'($urandom), 1, 0, 0, 0);

    access(0, 0, 1, 16'h1234, 8'hA5, 0, 0, 0, 0);
    access(0, 0, 0, 16'h1234, 8'h00, 0, 0, 0, 0);
    access(0, 0, 1, 16'h0100, 8'h55, 1, 0, 0, 0);
    access(0, 0, 1, 16'h0200, 8'h66, 1, 0, 0, 0);
    access(0, 0, 1, 16'h0200, 8'h67, 1, 1, 0, 0);
    access(0, 1, 1, 16'h0100, 8'h77, 1, 0, 1, 0);
    access(0, 1, 0, 16'h0100, 8'h00, 1, 0, 1, 1);
    access(0, 0, 1, 16'h4000, 8'h3C, 1, 0, 1, 0);
    access(0, 0, 0, 16'h4000, 8'h00, 1, 1, 0, 0);
    for (int k = 0; k < 150; k++) rand_access(0);

    access(1, 0, 1, 16'h1234, 8'hA5, 0, 0, 0, 0);
    access(1, 0, 0, 16'h1234, 8'h00, 0, 0, 0, 0);
    access(1, 1, 0, 16'h0100, 8'h00, 1, 0, 1, 1);
    for (int k = 0; k < 60; k++) rand_access(1);

    // Reset pulse during a read: no ack may follow.
    access(0, 0, 1, 16'h0100, 8'h11, 1, 0, 0, 0);
    sys_en[0] = 0;
    cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 16'h4000;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    cpu_req[0] = 0;
    #1;
    check("abort_cpu_ack", 32'(cpu_ack[0]), 32'd0);
    check("abort_ram_we", 32'(ram_we[0]), 32'd0);
    check("abort_wp_viol", 32'(wp_viol[0]), 32'd0);
    check("abort_ram_addr", 32'(ram_addr[0]), 32'd0);
    check("abort_cpu_rdata", 32'(cpu_rdata[0]), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    ref_viol[0] = 0;
    ref_viol[1] = 0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (cpu_ack[0] || sys_ack[0]) seen = 1;
    end
    check("no_ack_after_abort", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    access(0, 0, 0, 16'h4000, 8'h00, 1, 0, 0, 0);
    access(1, 0, 0, 16'h1234, 8'h00, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
